// File: rtl/fdc_pkg.sv
// -----------------------------------------------------------------------------
// fdc_pkg
// Shared definitions for the FDC measurement path: sequencer state encoding,
// measurement mode codes, path-select polarity and two small helpers that map
// a requested mode onto the mode actually run and its initial path select.
// -----------------------------------------------------------------------------
package fdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_OUT    = 3'd4
    } fdc_state_e;

    localparam logic [1:0] MODE_SYNC  = 2'b00;
    localparam logic [1:0] MODE_ASYNC = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;

    localparam logic SEL_SYNC  = 1'b1;
    localparam logic SEL_ASYNC = 1'b0;

    // The reserved code 11 runs as a plain synchronous measurement.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_SYNC : m;
    endfunction

    // Path select used for the first (or only) measurement of a mode.
    function automatic logic sel_for_mode(input logic [1:0] m);
        return (m == MODE_ASYNC) ? SEL_ASYNC : SEL_SYNC;
    endfunction

endpackage

// File: rtl/fdc_avg_acc.sv
// -----------------------------------------------------------------------------
// fdc_avg_acc
// Accumulates 2^LOG2_N samples of a DW-bit bus. The sum register is wide
// enough (DW+LOG2_N bits) that a full set of maximum-value samples cannot
// overflow it. Strobes beyond the last sample are ignored until cleared.
//
// Ports:
//   clk_ref_i  clock
//   reset_i    asynchronous active-high reset
//   clear_i    zero the sum and sample count (wins over strobe_i)
//   strobe_i   take data_i as the next sample
//   data_i     sample value, zero-extended into the sum
//   sum_o      running sum including any sample taken this cycle
//   done_o     high in the cycle the final sample of the set is taken
//
// sum_o/done_o look through the current strobe so a consumer can register
// the completed sum on the same edge that absorbs the last sample.
// -----------------------------------------------------------------------------
module fdc_avg_acc #(
    parameter int DW     = 5,
    parameter int LOG2_N = 3
) (
    input  logic                 clk_ref_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 strobe_i,
    input  logic [DW-1:0]        data_i,
    output logic [DW+LOG2_N-1:0] sum_o,
    output logic                 done_o
);

    localparam int AW = DW + LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    logic [AW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          take;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        take  = strobe_i && (cnt_q <= CNT_LAST);
        if (clear_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (take) begin
            sum_d = sum_q + AW'(data_i);
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign sum_o  = sum_d;
    assign done_o = !clear_i && take && (cnt_q == CNT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_ref_i or posedge reset_i) begin
        if (reset_i) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fdc_meas_ctrl.sv
// -----------------------------------------------------------------------------
// fdc_meas_ctrl
// Measurement sequencer for the synchronous/asynchronous FDC pair. A run
// selects a path, pulses the local FDC reset, waits for settling, averages
// 2^LOG2_N samples taken every SAMP_DIV cycles and offers the truncated
// average on a valid/ready interface. Mode 10 chains a sync then an async
// measurement; cont restarts a finished run with the same latched mode.
//
// Ports:
//   clk_ref    reference clock
//   reset      asynchronous active-high reset
//   start      one-cycle run request, ignored while busy
//   mode       00 sync, 01 async, 10 sync then async, 11 as 00
//   cont       restart automatically after a transfer
//   fdc_data   FDC result bus
//   fdc_selec  path select (1 sync, 0 async); only changes entering RST
//   fdc_rst    local FDC reset, high for RST_CYC cycles per measurement
//   res_data   averaged result
//   res_src    path select the result was measured on
//   res_valid  result available; held until res_ready
//   res_ready  consumer accepts the result
//   busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module fdc_meas_ctrl
    import fdc_pkg::*;
#(
    parameter int DW       = 5,
    parameter int LOG2_N   = 3,
    parameter int SETTLE   = 4,
    parameter int SAMP_DIV = 16,
    parameter int RST_CYC  = 2
) (
    input  logic          clk_ref,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          cont,
    input  logic [DW-1:0] fdc_data,
    output logic          fdc_selec,
    output logic          fdc_rst,
    output logic [DW-1:0] res_data,
    output logic          res_src,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy
);

    localparam int AW    = DW + LOG2_N;
    localparam int TMAX1 = (SETTLE > RST_CYC) ? SETTLE : RST_CYC;
    localparam int TMAX  = (SAMP_DIV > TMAX1) ? SAMP_DIV : TMAX1;
    // One shared timer serves all three timed phases; it counts 0..TMAX-1.
    localparam int TW    = $clog2(TMAX);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] DIV_LAST    = TW'(SAMP_DIV - 1);

    fdc_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    mode_q, mode_d;
    logic          sel_q, sel_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_src_q, res_src_d;
    logic          res_valid_q, res_valid_d;

    logic          acc_clear;
    logic          acc_strobe;
    logic [AW-1:0] acc_sum;
    logic          acc_done;

    fdc_avg_acc #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_acc (
        .clk_ref_i (clk_ref),
        .reset_i   (reset),
        .clear_i   (acc_clear),
        .strobe_i  (acc_strobe),
        .data_i    (fdc_data),
        .sum_o     (acc_sum),
        .done_o    (acc_done)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mode_d      = mode_q;
        sel_d       = sel_q;
        res_data_d  = res_data_q;
        res_src_d   = res_src_q;
        res_valid_d = res_valid_q;
        acc_clear   = 1'b0;
        acc_strobe  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = norm_mode(mode);
                    sel_d   = sel_for_mode(norm_mode(mode));
                    timer_d = '0;
                    state_d = ST_RST;
                end
            end

            ST_RST: begin
                acc_clear = 1'b1;
                if (timer_q == RST_LAST) begin
                    timer_d = '0;
                    state_d = ST_SETTLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_SAMPLE: begin
                if (timer_q == DIV_LAST) begin
                    timer_d    = '0;
                    acc_strobe = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                // Result is captured on the same edge as the final sample.
                if (acc_done) begin
                    res_data_d  = acc_sum[AW-1:LOG2_N];
                    res_src_d   = sel_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end

            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (mode_q == MODE_BOTH && sel_q == SEL_SYNC) begin
                        sel_d   = SEL_ASYNC;
                        state_d = ST_RST;
                    end else if (cont) begin
                        sel_d   = sel_for_mode(mode_q);
                        state_d = ST_RST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            mode_q      <= MODE_SYNC;
            sel_q       <= SEL_SYNC;
            res_data_q  <= '0;
            res_src_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            res_data_q  <= res_data_d;
            res_src_q   <= res_src_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign fdc_selec = sel_q;
    assign fdc_rst   = (state_q == ST_RST);
    assign busy      = (state_q != ST_IDLE);
    assign res_data  = res_data_q;
    assign res_src   = res_src_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_fdc_meas_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fdc_meas_ctrl
// Self-checking bench for fdc_meas_ctrl with default parameters. The reference
// model is a timeline: measured from the edge that starts a measurement
// (start accepted or previous transfer), fdc_rst is high in cycles 1..2,
// sample k is taken at edge 22+16k, and the result (the integer mean of the
// eight samples) appears in cycle 135. Only the exact sampling cycle carries
// the intended data; every other cycle drives random junk on fdc_data.
// -----------------------------------------------------------------------------
module tb_fdc_meas_ctrl;

    localparam int LAT      = 135;   // start edge to res_valid visible
    localparam int FIRST_SM = 22;    // edge of the first sample
    localparam int SDIV     = 16;

    logic       clk_ref = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic       cont;
    logic [4:0] fdc_data;
    logic       fdc_selec;
    logic       fdc_rst;
    logic [4:0] res_data;
    logic       res_src;
    logic       res_valid;
    logic       res_ready;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_ref = ~clk_ref;

    fdc_meas_ctrl dut (
        .clk_ref   (clk_ref),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .cont      (cont),
        .fdc_data  (fdc_data),
        .fdc_selec (fdc_selec),
        .fdc_rst   (fdc_rst),
        .res_data  (res_data),
        .res_src   (res_src),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Issue a start in the current cycle; it is taken at the next edge.
    task automatic do_start(input logic [1:0] m);
        @(negedge clk_ref);
        start = 1'b1;
        mode  = m;
    endtask

    // Follows one measurement from the cycle after its starting edge up to
    // the cycle before its transfer edge. start_at pulses a stray start in
    // that cycle (0 = none). Returns with res_ready=1 driven for the transfer.
    task automatic measure(input logic exp_sel, input int vals[8], input int bp,
                           input int start_at, input logic cont_v);
        int       sum;
        logic [4:0] exp_avg;
        sum = 0;
        for (int k = 0; k < 8; k++) sum += vals[k];
        exp_avg = 5'(sum / 8);

        for (int c = 1; c < LAT; c++) begin
            @(negedge clk_ref);
            check("fdc_rst", fdc_rst, (c <= 2) ? 1 : 0);
            check("busy", busy, 1);
            check("selec", fdc_selec, exp_sel);
            check("valid_early", res_valid, 0);
            fdc_data = 5'($urandom_range(0, 31));
            for (int k = 0; k < 8; k++)
                if (c == FIRST_SM + SDIV * k) fdc_data = 5'(vals[k]);
            res_ready = 1'($urandom_range(0, 1));
            mode      = 2'($urandom_range(0, 3));
            start     = (c == start_at);
            cont      = cont_v;
        end

        @(negedge clk_ref);
        check("valid", res_valid, 1);
        check("res_data", res_data, exp_avg);
        check("res_src", res_src, exp_sel);
        check("selec_out", fdc_selec, exp_sel);
        start = 1'b0;

        for (int d = 0; d < bp; d++) begin
            res_ready = 1'b0;
            fdc_data  = 5'($urandom_range(0, 31));
            @(negedge clk_ref);
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, exp_avg);
            check("bp_src", res_src, exp_sel);
            check("bp_rst", fdc_rst, 0);
            check("bp_busy", busy, 1);
        end
        res_ready = 1'b1;
    endtask

    task automatic expect_idle(input logic exp_sel);
        @(negedge clk_ref);
        check("idle_busy", busy, 0);
        check("idle_valid", res_valid, 0);
        check("idle_selec", fdc_selec, exp_sel);
        check("idle_rst", fdc_rst, 0);
        res_ready = 1'b0;
        start     = 1'b0;
    endtask

    task automatic fill_const(output int v[8], input int val);
        for (int k = 0; k < 8; k++) v[k] = val;
    endtask

    task automatic fill_rand(output int v[8]);
        for (int k = 0; k < 8; k++) v[k] = $urandom_range(0, 31);
    endtask

    initial begin
        int v[8];
        int w[8];
        int m;

        reset     = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        cont      = 1'b0;
        fdc_data  = '0;
        res_ready = 1'b0;

        // Reset values, then a long idle stretch with noisy inputs.
        repeat (3) @(negedge clk_ref);
        check("rst_selec", fdc_selec, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_fdc_rst", fdc_rst, 0);
        check("rst_data", res_data, 0);
        check("rst_src", res_src, 0);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            fdc_data  = 5'($urandom_range(0, 31));
            res_ready = 1'($urandom_range(0, 1));
            mode      = 2'($urandom_range(0, 3));
            cont      = 1'($urandom_range(0, 1));
            @(negedge clk_ref);
            check("idle_selec", fdc_selec, 1);
            check("idle_busy", busy, 0);
            check("idle_valid", res_valid, 0);
            check("idle_rst", fdc_rst, 0);
            check("idle_data", res_data, 0);
            check("idle_src", res_src, 0);
        end
        cont = 1'b0;

        // Mode 00, constant 19.
        fill_const(v, 19);
        do_start(2'b00);
        measure(1'b1, v, 0, 0, 1'b0);
        expect_idle(1'b1);

        // Mode 10: ramp on the sync path, then constant 31 on the async path.
        for (int k = 0; k < 8; k++) v[k] = k;
        fill_const(w, 31);
        do_start(2'b10);
        measure(1'b1, v, 0, 0, 1'b0);
        measure(1'b0, w, 0, 0, 1'b0);
        expect_idle(1'b0);
        repeat (5) expect_idle(1'b0);

        // Backpressure: 50 cycles of res_ready low in OUT.
        fill_rand(v);
        do_start(2'b01);
        measure(1'b0, v, 50, 0, 1'b0);
        expect_idle(1'b0);

        // Reset while the 4th sample is being taken, then a clean async run.
        do_start(2'b00);
        for (int c = 1; c <= FIRST_SM + SDIV * 3; c++) begin
            @(negedge clk_ref);
            start    = 1'b0;
            fdc_data = 5'd31;
        end
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_selec", fdc_selec, 1);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_fdc_rst", fdc_rst, 0);
        @(negedge clk_ref);
        reset = 1'b0;
        fill_const(v, 7);
        do_start(2'b01);
        measure(1'b0, v, 0, 0, 1'b0);
        expect_idle(1'b0);

        // Mode 11 with cont: back-to-back sync runs, stray start ignored,
        // dropping cont ends after the following transfer.
        fill_rand(v);
        do_start(2'b11);
        cont = 1'b1;
        measure(1'b1, v, 0, 40, 1'b1);
        fill_rand(v);
        measure(1'b1, v, 2, 90, 1'b1);
        fill_rand(v);
        measure(1'b1, v, 0, 0, 1'b0);
        expect_idle(1'b1);

        // Random single runs across all mode codes.
        for (int r = 0; r < 5; r++) begin
            m = $urandom_range(0, 3);
            fill_rand(v);
            do_start(2'(m));
            measure((m == 1) ? 1'b0 : 1'b1, v, $urandom_range(0, 5), 0, 1'b0);
            if (m == 2) begin
                fill_rand(w);
                measure(1'b0, w, $urandom_range(0, 5), 0, 1'b0);
            end
            expect_idle((m == 1 || m == 2) ? 1'b0 : 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
